data_memory_hs: RTL and testbench
=================================

// Module: data_memory_hs
// PURPOSE
//  Parametrised successor to the single-cycle data memory: word-organised RAM with byte/half/word access.
//  Sign/zero-extended loads; valid/ready request and response handshake; programmable read latency.
//  Sits between the MEM stage and backing storage; one outstanding transaction; misaligned access flagged.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words (power of two, >=16)
//  ADDR_W       32    byte-address width
//  LATENCY      1     cycles from request accept to RespValid (1..4)
//  INIT_FILE    ""    $readmemh image loaded at elaboration; empty = none
// PORTS
//  Clk        in   1       rising-edge clock
//  Rst_n      in   1       asynchronous active-low reset
//  ReqValid   in   1       request present
//  ReqReady   out  1       block can accept request
//  ReqWrite   in   1       1 = store, 0 = load
//  ReqSize    in   2       00 byte, 01 half, 10 word, 11 reserved
//  ReqSigned  in   1       load sign-extends when 1 (ignored for word/stores)
//  Address    in   ADDR_W  byte address
//  WriteData  in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  RespValid  out  1       response present
//  RespReady  in   1       consumer takes response
//  ReadData   out  32      load result; 0 for stores and errors
//  RespError  out  1       misaligned/reserved-size (/out-of-range) access
// BEHAVIOUR
//  - Reset (async, Rst_n=0): state IDLE, RespValid=0, ReadData=0, RespError=0, ReqReady=0 while Rst_n low.
//  - RAM contents not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    - ReqReady = (state==IDLE) & Rst_n; accept on ReqValid & ReqReady.
//  - Accept edge: store commits to RAM and load data is sampled, both at this edge.
//    - LATENCY==1: next state RESP. Else WAIT with cnt=LATENCY-1.
//  - WAIT: cnt decrements each cycle; RESP entered when cnt reaches 1 -> RespValid rises exactly LATENCY cycles after accept.
//  - RESP: RespValid=1; ReadData/RespError held stable until RespValid & RespReady, then IDLE.
//    - New request not accepted in the handshake cycle (ReqReady is 0 until IDLE).
//  - Word index = Address[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (aliasing) unless bounds check enabled.
//  - Stores: byte writes lane Address[1:0]; half writes lanes {Address[1],0} and {Address[1],1}; word writes all four. Other lanes untouched.
//  - Loads: lane extracted as above; byte/half zero-extended, or sign-extended when ReqSigned=1.
//  - Error (half with Address[0]=1; word with Address[1:0]!=0; ReqSize=11):
//    - no RAM write; response still issued with RespError=1, ReadData=0.
//  - Stores return a response with ReadData=0, RespError=0 (write acknowledge).
//  - Reset mid-transaction: transaction abandoned, no response; a store committed at its accept edge persists.
// CONFIGURATION
//  DMEM_BOUNDS_CHECK_EN defined:
//    - Address >= DEPTH_WORDS*4 is an error: no write, RespError=1, ReadData=0.
//  Undefined:
//    - upper bits ignored; address wraps modulo DEPTH_WORDS*4.
// STRUCTURE
//  dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state typedef, function computing byte-enable mask and alignment error.
//  Sub-module dmem_lane_align: combinational load extract/extend and store byte-enable/replication; top holds FSM, latency counter, RAM.
// TESTING (default params unless noted)
//  1. SW 0xDEADBEEF @0x4; LW @0x4 -> 0xDEADBEEF, RespError=0; RespValid exactly LATENCY cycles after accept (run LATENCY=1 and 4).
//  2. SB 0xA5 @0x5; LB signed @0x5 -> 0xFFFFFFA5; LBU @0x5 -> 0x000000A5; LW @0x4 -> 0xDEADA5EF.
//  3. SH 0x8001 @0x6; LH signed @0x6 -> 0xFFFF8001; LW @0x6 -> RespError=1, ReadData=0; LW @0x4 -> 0x8001A5EF.
//  4. RespReady held low 5 cycles: RespValid, ReadData stable; ReqReady=0; concurrent ReqValid not accepted until after handshake.
//  5. LATENCY=3, Rst_n low during WAIT of a load: RespValid=0 immediately, no response after release, ReqReady=1 next cycle.
//  6. SW 0x12345678 @DEPTH_WORDS*4: with DMEM_BOUNDS_CHECK_EN -> RespError=1, word 0 unchanged; without -> LW @0x0 returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: access-size encodings,
// controller state type and the lane/alignment decode used by the lane aligner.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmemState_t;

    typedef struct packed {
        logic [3:0] byteEn;
        logic       alignErr;
    } laneAccess_t;

    // Byte lanes touched by an access, plus misaligned/reserved-size flag.
    // A faulting access touches no lanes.
    function automatic laneAccess_t laneAccess(input logic [1:0] size, input logic [1:0] addrLow);
        laneAccess_t acc;
        acc.byteEn   = 4'b0000;
        acc.alignErr = 1'b0;
        case (size)
            SZ_BYTE: acc.byteEn = 4'b0001 << addrLow;
            SZ_HALF: begin
                acc.byteEn   = addrLow[1] ? 4'b1100 : 4'b0011;
                acc.alignErr = addrLow[0];
            end
            SZ_WORD: begin
                acc.byteEn   = 4'b1111;
                acc.alignErr = (addrLow != 2'b00);
            end
            default: acc.alignErr = 1'b1;
        endcase
        if (acc.alignErr) begin
            acc.byteEn = 4'b0000;
        end
        return acc;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and data replication,
// load lane extraction with zero/sign extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [1:0]  addrLow,
    input  logic [31:0] writeData,
    input  logic [31:0] ramWord,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord,
    output logic [31:0] loadData,
    output logic        alignErr
);

    laneAccess_t        acc;
    logic [31:0]        shifted;
    logic signed [7:0]  loadByte;
    logic signed [15:0] loadHalf;

    assign acc      = laneAccess(reqSize, addrLow);
    assign byteEn   = acc.byteEn;
    assign alignErr = acc.alignErr;
    assign shifted  = ramWord >> {addrLow, 3'b000};
    assign loadByte = $signed(shifted[7:0]);
    assign loadHalf = $signed(shifted[15:0]);

    // Replicate store data across lanes so the enabled lane always sees it; extract and extend loads.
    always_comb begin
        storeWord = writeData;
        loadData  = 32'h0;
        case (reqSize)
            SZ_BYTE: begin
                storeWord = {4{writeData[7:0]}};
                loadData  = reqSigned ? {{24{loadByte[7]}}, loadByte} : {24'h0, loadByte};
            end
            SZ_HALF: begin
                storeWord = {2{writeData[15:0]}};
                loadData  = reqSigned ? {{16{loadHalf[15]}}, loadHalf} : {16'h0, loadHalf};
            end
            SZ_WORD: loadData = ramWord;
            default: loadData = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// Word-organised data memory with byte/half/word access, valid/ready request
// and response handshakes and a fixed, programmable read latency.
// Optional build macro DMEM_BOUNDS_CHECK_EN: addresses beyond the array are
// faulted instead of aliasing onto it.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [31:0]       ReadData,
    output logic              RespError
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    dmemState_t       state, nextState;
    logic [2:0]       cnt, nextCnt;
    logic [IDX_W-1:0] wordIdx;
    logic [3:0]       byteEn;
    logic [31:0]      storeWord, loadData, respData;
    logic             alignErr, outOfRange, reqError, accept, respErr;

    assign wordIdx  = Address[IDX_W+1:2];
    assign ReqReady = (state == ST_IDLE) & Rst_n;
    assign accept   = ReqValid & ReqReady;
    assign reqError = alignErr | outOfRange;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS * 4);
    assign outOfRange = ({1'b0, Address} >= ADDR_LIMIT);
`else
    logic unusedAddrHigh;
    assign outOfRange     = 1'b0;
    assign unusedAddrHigh = ^Address[ADDR_W-1:IDX_W+2];
`endif

    dmem_lane_align uLaneAlign (
        .reqSize   (ReqSize),
        .reqSigned (ReqSigned),
        .addrLow   (Address[1:0]),
        .writeData (WriteData),
        .ramWord   (mem[wordIdx]),
        .byteEn    (byteEn),
        .storeWord (storeWord),
        .loadData  (loadData),
        .alignErr  (alignErr)
    );

    // Controller state and latency counter; reset abandons any transaction.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // Next state: IDLE -> (WAIT while counting down) -> RESP -> IDLE on handshake.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        nextState = ST_RESP;
                    end else begin
                        nextState = ST_WAIT;
                        nextCnt   = 3'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd1) nextState = ST_RESP;
                else             nextCnt   = cnt - 3'd1;
            end
            ST_RESP: begin
                if (RespReady) nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Store commit at the accept edge; faulting accesses write nothing.
    always_ff @(posedge Clk) begin
        if (accept && ReqWrite && !reqError) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeWord[8*i +: 8];
            end
        end
    end

    // Capture the response at the accept edge; held until the handshake.
    always_ff @(posedge Clk) begin
        if (accept) begin
            respData <= (ReqWrite || reqError) ? 32'h0 : loadData;
            respErr  <= reqError;
        end
    end

    assign RespValid = (state == ST_RESP);
    assign ReadData  = RespValid ? respData : 32'h0;
    assign RespError = RespValid & respErr;

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: three instances (latency 1, 3, 4) share
// stimulus; only the selected instance sees ReqValid.
module tb_data_memory_hs;
    import dmem_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = SZ_WORD;
    logic        ReqSigned = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        RespReady = 1'b1;
    logic [1:0]  sel = 2'd0;

    logic [2:0]  reqValidV;
    logic        reqReadyV [3];
    logic        respValidV [3];
    logic [31:0] readDataV [3];
    logic        respErrorV [3];
    logic        reqReadyS, respValidS, respErrorS;
    logic [31:0] readDataS;

    int nChecks = 0;
    int nErrors = 0;

    assign reqValidV  = ReqValid ? (3'b001 << sel) : 3'b000;
    assign reqReadyS  = reqReadyV[sel];
    assign respValidS = respValidV[sel];
    assign readDataS  = readDataV[sel];
    assign respErrorS = respErrorV[sel];

    always #5 Clk = ~Clk;

    data_memory_hs #(.LATENCY(1)) uDutLat1 (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(reqValidV[0]), .ReqReady(reqReadyV[0]),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .Address(Address),
        .WriteData(WriteData), .RespValid(respValidV[0]), .RespReady(RespReady),
        .ReadData(readDataV[0]), .RespError(respErrorV[0]));

    data_memory_hs #(.LATENCY(3)) uDutLat3 (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(reqValidV[1]), .ReqReady(reqReadyV[1]),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .Address(Address),
        .WriteData(WriteData), .RespValid(respValidV[1]), .RespReady(RespReady),
        .ReadData(readDataV[1]), .RespError(respErrorV[1]));

    data_memory_hs #(.LATENCY(4)) uDutLat4 (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(reqValidV[2]), .ReqReady(reqReadyV[2]),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .Address(Address),
        .WriteData(WriteData), .RespValid(respValidV[2]), .RespReady(RespReady),
        .ReadData(readDataV[2]), .RespError(respErrorV[2]));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full transaction with RespReady high; returns data, error and accept-to-RespValid cycles.
    task automatic doTxn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int waitCnt;
        @(negedge Clk);
        ReqWrite = wr; ReqSize = sz; ReqSigned = sg; Address = addr; WriteData = wd;
        RespReady = 1'b1; ReqValid = 1'b1;
        waitCnt = 0;
        while (!reqReadyS && waitCnt < 20) begin
            @(negedge Clk);
            waitCnt++;
        end
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!respValidS && lat < 20);
        rd = readDataS;
        er = respErrorS;
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          badValid;

    initial begin
        // Reset state
        #12;
        checkVal("rst_ReqReady", 32'(reqReadyS), 32'd0);
        checkVal("rst_RespValid", 32'(respValidS), 32'd0);
        checkVal("rst_ReadData", readDataS, 32'h0);
        checkVal("rst_RespError", 32'(respErrorS), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Word store/load, latency 1
        sel = 2'd0;
        doTxn(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEADBEEF, rd, er, lat);
        checkVal("sw_data", rd, 32'h0);
        checkVal("sw_err", 32'(er), 32'd0);
        checkVal("sw_lat1", 32'(lat), 32'd1);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
        checkVal("lw_data", rd, 32'hDEADBEEF);
        checkVal("lw_err", 32'(er), 32'd0);
        checkVal("lw_lat1", 32'(lat), 32'd1);

        // Byte store, signed/unsigned byte loads
        doTxn(1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h000000A5, rd, er, lat);
        doTxn(1'b0, SZ_BYTE, 1'b1, 32'h5, 32'h0, rd, er, lat);
        checkVal("lb_signed", rd, 32'hFFFFFFA5);
        doTxn(1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0, rd, er, lat);
        checkVal("lbu", rd, 32'h000000A5);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
        checkVal("lw_after_sb", rd, 32'hDEADA5EF);

        // Half store, signed half load, misaligned word load
        doTxn(1'b1, SZ_HALF, 1'b0, 32'h6, 32'h00008001, rd, er, lat);
        checkVal("sh_err", 32'(er), 32'd0);
        doTxn(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, rd, er, lat);
        checkVal("lh_signed", rd, 32'hFFFF8001);
        doTxn(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, rd, er, lat);
        checkVal("lhu", rd, 32'h00008001);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0, rd, er, lat);
        checkVal("lw_mis_err", 32'(er), 32'd1);
        checkVal("lw_mis_data", rd, 32'h0);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
        checkVal("lw_after_sh", rd, 32'h8001A5EF);

        // Faulting stores must not write
        doTxn(1'b1, SZ_HALF, 1'b0, 32'h5, 32'h00001111, rd, er, lat);
        checkVal("sh_mis_err", 32'(er), 32'd1);
        doTxn(1'b1, 2'b11, 1'b0, 32'h4, 32'h22222222, rd, er, lat);
        checkVal("rsvd_err", 32'(er), 32'd1);
        checkVal("rsvd_data", rd, 32'h0);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
        checkVal("lw_after_faults", rd, 32'h8001A5EF);

        // Latency 4 instance
        sel = 2'd2;
        doTxn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hCAFEF00D, rd, er, lat);
        checkVal("sw_lat4", 32'(lat), 32'd4);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checkVal("lw_lat4", 32'(lat), 32'd4);
        checkVal("lw_lat4_data", rd, 32'hCAFEF00D);

        // Back-pressure on the response
        sel = 2'd0;
        doTxn(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h55AA1234, rd, er, lat);
        @(negedge Clk);
        ReqWrite = 1'b0; ReqSize = SZ_WORD; ReqSigned = 1'b0; Address = 32'h8;
        RespReady = 1'b0; ReqValid = 1'b1;
        @(posedge Clk);
        #1 Address = 32'h4;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checkVal("bp_RespValid", 32'(respValidS), 32'd1);
            checkVal("bp_ReadData", readDataS, 32'h55AA1234);
            checkVal("bp_ReqReady", 32'(reqReadyS), 32'd0);
        end
        RespReady = 1'b1;
        @(negedge Clk);
        checkVal("bp_post_hs_valid", 32'(respValidS), 32'd0);
        checkVal("bp_post_hs_ready", 32'(reqReadyS), 32'd1);
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        @(negedge Clk);
        checkVal("bp_second_valid", 32'(respValidS), 32'd1);
        checkVal("bp_second_data", readDataS, 32'h8001A5EF);
        @(posedge Clk);
        #1;

        // Reset during WAIT on the latency 3 instance
        sel = 2'd1;
        @(negedge Clk);
        ReqWrite = 1'b0; ReqSize = SZ_WORD; Address = 32'h4; RespReady = 1'b1; ReqValid = 1'b1;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checkVal("rstw_RespValid", 32'(respValidS), 32'd0);
        checkVal("rstw_ReqReady", 32'(reqReadyS), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        checkVal("rstw_ReqReady_after", 32'(reqReadyS), 32'd1);
        badValid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (respValidS) badValid++;
        end
        checkVal("rstw_no_resp", 32'(badValid), 32'd0);

        // Address at the top of the array
        sel = 2'd0;
        doTxn(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0BADF00D, rd, er, lat);
        doTxn(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h12345678, rd, er, lat);
`ifdef DMEM_BOUNDS_CHECK_EN
        checkVal("oob_err", 32'(er), 32'd1);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, rd, er, lat);
        checkVal("oob_word0", rd, 32'h0BADF00D);
`else
        checkVal("wrap_err", 32'(er), 32'd0);
        doTxn(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, rd, er, lat);
        checkVal("wrap_word0", rd, 32'h12345678);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
